simple_mem_ctrl: RTL and testbench

Controller that sequences a single-port synchronous memory (18-bit words, 1-cycle registered read) and shares it between two requesters.
- After reset it runs an init sequence that writes each word with its own index.
- It then arbitrates read/write requests round-robin, one access per cycle.
- It returns read data to the requester that issued the read.
- It sits between two client blocks and the memory macro's address, write-enable and data pins.

---
 rtl/simple_mem_ctrl.sv | 122 ++++++++++++
 tb/tb_simple_mem_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/simple_mem_ctrl.sv
// Two-requester controller for a single-port synchronous memory: index-fill init after
// reset, then round-robin arbitration with one access per cycle and routed read responses.
module simple_mem_ctrl #(
    parameter int unsigned DATA_W   = 18,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned MEM_SIZE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              init_done
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] init_cnt;
    logic              ptr;
    logic              pend0, pend1, pend_ok;
    logic [DATA_W-1:0] hold0, hold1;

    logic              grant0, grant1;
    logic              sel_we, sel_ok;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] rsp_word;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == ST_RUN) begin
            if (req0_valid && (!req1_valid || !ptr))
                grant0 = 1'b1;
            else if (req1_valid)
                grant1 = 1'b1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign sel_we    = grant1 ? req1_we    : req0_we;
    assign sel_addr  = grant1 ? req1_addr  : req0_addr;
    assign sel_wdata = grant1 ? req1_wdata : req0_wdata;
    assign sel_ok    = 32'(sel_addr) < MEM_SIZE;

    // State sits at INIT while reset is held, so the init drive is masked by rst_n
    // to keep the memory pins quiet during reset.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst_n && state == ST_INIT) begin
            mem_we    = 1'b1;
            mem_addr  = init_cnt;
            mem_wdata = DATA_W'(init_cnt);
        end else if (grant0 || grant1) begin
            mem_we    = sel_we && sel_ok;
            mem_addr  = sel_addr;
            mem_wdata = sel_we ? sel_wdata : '0;
        end
    end

    assign rsp_word   = pend_ok ? mem_rdata : '0;
    assign rsp0_valid = pend0;
    assign rsp1_valid = pend1;
    assign rsp0_data  = pend0 ? rsp_word : hold0;
    assign rsp1_data  = pend1 ? rsp_word : hold1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            ptr       <= 1'b0;
            init_done <= 1'b0;
            pend0     <= 1'b0;
            pend1     <= 1'b0;
            pend_ok   <= 1'b0;
            hold0     <= '0;
            hold1     <= '0;
        end else begin
            if (state == ST_INIT) begin
                if (32'(init_cnt) == MEM_SIZE - 1) begin
                    state     <= ST_RUN;
                    init_done <= 1'b1;
                end else begin
                    init_cnt <= init_cnt + ADDR_W'(1);
                end
            end else begin
                if (grant0)
                    ptr <= 1'b1;
                else if (grant1)
                    ptr <= 1'b0;
            end
            pend0   <= grant0 && !req0_we;
            pend1   <= grant1 && !req1_we;
            pend_ok <= sel_ok;
            if (pend0)
                hold0 <= rsp_word;
            if (pend1)
                hold1 <= rsp_word;
        end
    end

endmodule

// File: tb/tb_simple_mem_ctrl.sv
// Table-driven bench for simple_mem_ctrl with a 4-word registered-read memory model.
module tb_simple_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_we;
    logic [7:0]  req0_addr;
    logic [17:0] req0_wdata;
    logic        rsp0_valid;
    logic [17:0] rsp0_data;
    logic        req1_valid, req1_ready, req1_we;
    logic [7:0]  req1_addr;
    logic [17:0] req1_wdata;
    logic        rsp1_valid;
    logic [17:0] rsp1_data;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [17:0] mem_wdata;
    logic [17:0] mem_rdata;
    logic        init_done;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    simple_mem_ctrl #(.DATA_W(18), .ADDR_W(8), .MEM_SIZE(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    // Out-of-range reads return a non-zero pattern so the controller's zeroing is visible.
    logic [17:0] mem_arr [4];
    initial begin
        for (int i = 0; i < 4; i++) mem_arr[i] = 18'h15555;
        mem_rdata = '0;
    end
    always @(posedge clk) begin
        if (mem_we && mem_addr < 8'd4) mem_arr[mem_addr[1:0]] <= mem_wdata;
        mem_rdata <= (mem_addr < 8'd4) ? mem_arr[mem_addr[1:0]] : 18'h2AAAA;
    end

    typedef struct {
        logic [27:0] q0;
        logic [27:0] q1;
        logic [67:0] exp;
    } vec_t;

    vec_t tbl [18];

    localparam logic [27:0] NO = 28'd0;

    function automatic logic [27:0] RD(input logic [7:0] a);
        return {1'b1, 1'b0, a, 18'd0};
    endfunction

    function automatic logic [27:0] WR(input logic [7:0] a, input logic [17:0] d);
        return {1'b1, 1'b1, a, d};
    endfunction

    function automatic logic [67:0] EX(input logic r0, input logic r1, input logic mwe,
                                       input logic [7:0] maddr, input logic [17:0] mwd,
                                       input logic rv0, input logic [17:0] rd0,
                                       input logic rv1, input logic [17:0] rd1,
                                       input logic idn);
        return {r0, r1, mwe, maddr, mwd, rv0, rd0, rv1, rd1, idn};
    endfunction

    task automatic apply(input logic [27:0] q0, input logic [27:0] q1,
                         input logic [67:0] exp, input string name);
        logic [67:0] got;
        {req0_valid, req0_we, req0_addr, req0_wdata} = q0;
        {req1_valid, req1_we, req1_addr, req1_wdata} = q1;
        @(negedge clk);
        got = {req0_ready, req1_ready, mem_we, mem_addr, mem_wdata,
               rsp0_valid, rsp0_data, rsp1_valid, rsp1_data, init_done};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got rdy=%b%b we=%b addr=%h wd=%h rsp0=%b/%h rsp1=%b/%h idone=%b ; expected %h",
                     name, got[67], got[66], got[65], got[64:57], got[56:39],
                     got[38], got[37:20], got[19], got[18:1], got[0], exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Cycle 1 is the first cycle after reset release; req0 holds a read of addr 2 through init.
        tbl[0]  = '{RD(8'd2), NO, EX(0,0,1,8'd0,18'd0, 0,18'd0,       0,18'd0,       0)};
        tbl[1]  = '{RD(8'd2), NO, EX(0,0,1,8'd1,18'd1, 0,18'd0,       0,18'd0,       0)};
        tbl[2]  = '{RD(8'd2), NO, EX(0,0,1,8'd2,18'd2, 0,18'd0,       0,18'd0,       0)};
        tbl[3]  = '{RD(8'd2), NO, EX(0,0,1,8'd3,18'd3, 0,18'd0,       0,18'd0,       0)};
        tbl[4]  = '{RD(8'd2), NO, EX(1,0,0,8'd2,18'd0, 0,18'd0,       0,18'd0,       1)};
        tbl[5]  = '{NO, NO,       EX(0,0,0,8'd0,18'd0, 1,18'd2,       0,18'd0,       1)};
        tbl[6]  = '{NO, RD(8'd0), EX(0,1,0,8'd0,18'd0, 0,18'd2,       0,18'd0,       1)};
        tbl[7]  = '{RD(8'd1), RD(8'd3), EX(1,0,0,8'd1,18'd0, 0,18'd2, 1,18'd0,       1)};
        tbl[8]  = '{RD(8'd1), RD(8'd3), EX(0,1,0,8'd3,18'd0, 1,18'd1, 0,18'd0,       1)};
        tbl[9]  = '{RD(8'd1), RD(8'd3), EX(1,0,0,8'd1,18'd0, 0,18'd1, 1,18'd3,       1)};
        tbl[10] = '{RD(8'd1), RD(8'd3), EX(0,1,0,8'd3,18'd0, 1,18'd1, 0,18'd3,       1)};
        tbl[11] = '{NO, NO,       EX(0,0,0,8'd0,18'd0, 0,18'd1,       1,18'd3,       1)};
        tbl[12] = '{NO, WR(8'd0,18'h3FFFF), EX(0,1,1,8'd0,18'h3FFFF, 0,18'd1, 0,18'd3, 1)};
        tbl[13] = '{NO, RD(8'd0), EX(0,1,0,8'd0,18'd0, 0,18'd1,       0,18'd3,       1)};
        tbl[14] = '{WR(8'd200,18'h12345), NO, EX(1,0,0,8'd200,18'h12345, 0,18'd1, 1,18'h3FFFF, 1)};
        tbl[15] = '{RD(8'd200), NO, EX(1,0,0,8'd200,18'd0, 0,18'd1,   0,18'h3FFFF,   1)};
        tbl[16] = '{RD(8'd0), NO, EX(1,0,0,8'd0,18'd0,   1,18'd0,     0,18'h3FFFF,   1)};
        tbl[17] = '{NO, NO,       EX(0,0,0,8'd0,18'd0,   1,18'h3FFFF, 0,18'h3FFFF,   1)};

        rst_n = 1'b0;
        {req0_valid, req0_we, req0_addr, req0_wdata} = NO;
        {req1_valid, req1_we, req1_addr, req1_wdata} = NO;
        repeat (2) @(posedge clk);
        #1;
        apply(NO, NO, '0, "reset_state");
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++)
            apply(tbl[i].q0, tbl[i].q1, tbl[i].exp, $sformatf("vec%0d", i));

        // Read accepted, then reset lands in its response cycle: nothing may come back.
        apply(RD(8'd2), NO, EX(1,0,0,8'd2,18'd0, 0,18'h3FFFF, 0,18'h3FFFF, 1), "read_before_reset");
        rst_n = 1'b0;
        apply(NO, NO, '0, "reset_abort");
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++)
            apply(tbl[i].q0, tbl[i].q1, tbl[i].exp, $sformatf("reinit_vec%0d", i));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
